// File: rtl/tq_zigzag_scan.sv
// tq_zigzag_scan: accepts a quantized 4x4 block and streams its coefficients
// in zigzag order, one beat per valid/ready handshake, with the block's
// nonzero count alongside.
// Optional build macro TQ_ZZ_SKIP_TRAIL_EN: end the scan at the highest
// zigzag index holding a nonzero coefficient instead of always at index 15.
module tq_zigzag_scan #(
   parameter int COEF_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [COEF_W-1:0] coeff00_i,
   input  logic [COEF_W-1:0] coeff01_i,
   input  logic [COEF_W-1:0] coeff02_i,
   input  logic [COEF_W-1:0] coeff03_i,
   input  logic [COEF_W-1:0] coeff10_i,
   input  logic [COEF_W-1:0] coeff11_i,
   input  logic [COEF_W-1:0] coeff12_i,
   input  logic [COEF_W-1:0] coeff13_i,
   input  logic [COEF_W-1:0] coeff20_i,
   input  logic [COEF_W-1:0] coeff21_i,
   input  logic [COEF_W-1:0] coeff22_i,
   input  logic [COEF_W-1:0] coeff23_i,
   input  logic [COEF_W-1:0] coeff30_i,
   input  logic [COEF_W-1:0] coeff31_i,
   input  logic [COEF_W-1:0] coeff32_i,
   input  logic [COEF_W-1:0] coeff33_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [COEF_W-1:0] coeff_o,
   output logic [3:0]        coeff_idx_o,
   output logic              coeff_valid_o,
   input  logic              coeff_ready_i,
   output logic              coeff_last_o,
   output logic [4:0]        nz_cnt_o
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state, state_nxt;
   logic [COEF_W-1:0] zz_in  [16];
   logic [COEF_W-1:0] zz_buf [16];
   logic [3:0]        cnt;
   logic [3:0]        end_idx;
   logic [4:0]        nz_in;
   logic              accept;
   logic              beat_fire;

   // Reorder the incoming block into zigzag order so the buffer is stored
   // already scanned and the output mux is indexed directly by the counter.
   always_comb begin
      zz_in[0]  = coeff00_i;
      zz_in[1]  = coeff01_i;
      zz_in[2]  = coeff10_i;
      zz_in[3]  = coeff20_i;
      zz_in[4]  = coeff11_i;
      zz_in[5]  = coeff02_i;
      zz_in[6]  = coeff03_i;
      zz_in[7]  = coeff12_i;
      zz_in[8]  = coeff21_i;
      zz_in[9]  = coeff30_i;
      zz_in[10] = coeff31_i;
      zz_in[11] = coeff22_i;
      zz_in[12] = coeff13_i;
      zz_in[13] = coeff23_i;
      zz_in[14] = coeff32_i;
      zz_in[15] = coeff33_i;
   end

   // Count nonzero coefficients of the incoming block.
   always_comb begin
      nz_in = '0;
      for (int unsigned k = 0; k < 16; k++) begin
         nz_in = nz_in + 5'(zz_in[k] != '0);
      end
   end

`ifdef TQ_ZZ_SKIP_TRAIL_EN
   logic [3:0] end_in;
   logic [3:0] end_idx_q;

   // Highest zigzag index with a nonzero value; 0 for an all-zero block.
   always_comb begin
      end_in = '0;
      for (int unsigned k = 0; k < 16; k++) begin
         if (zz_in[k] != '0) end_in = 4'(k);
      end
   end

   // Capture the scan end point together with the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      end_idx_q <= '0;
      else if (accept) end_idx_q <= end_in;
   end

   assign end_idx = end_idx_q;
`else
   assign end_idx = 4'd15;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt     = state;
      in_ready_o    = 1'b0;
      coeff_valid_o = 1'b0;
      coeff_last_o  = 1'b0;
      accept        = 1'b0;
      beat_fire     = 1'b0;
      case (state)
         IDLE: begin
            in_ready_o = 1'b1;
            accept     = in_valid_i;
            if (in_valid_i) state_nxt = SCAN;
         end
         SCAN: begin
            coeff_valid_o = 1'b1;
            coeff_last_o  = (cnt == end_idx);
            beat_fire     = coeff_ready_i;
            if (coeff_ready_i && (cnt == end_idx)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Block buffer, scan counter and nonzero count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         nz_cnt_o <= '0;
         for (int unsigned k = 0; k < 16; k++) zz_buf[k] <= '0;
      end else if (accept) begin
         cnt      <= '0;
         nz_cnt_o <= nz_in;
         for (int unsigned k = 0; k < 16; k++) zz_buf[k] <= zz_in[k];
      end else if (beat_fire) begin
         cnt <= (cnt == end_idx) ? 4'd0 : cnt + 4'd1;
      end
   end

   assign coeff_o     = zz_buf[cnt];
   assign coeff_idx_o = cnt;

endmodule

// File: tb/tb_tq_zigzag_scan.sv
// Directed bench for tq_zigzag_scan: ramp block, backpressure, sparse and
// all-zero blocks, reset mid-scan, and input held valid during a scan.
module tb_tq_zigzag_scan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] blk [16];
   logic        in_valid_i;
   logic        in_ready_o;
   logic [14:0] coeff_o;
   logic [3:0]  coeff_idx_o;
   logic        coeff_valid_o;
   logic        coeff_ready_i;
   logic        coeff_last_o;
   logic [4:0]  nz_cnt_o;

   int n_vec = 0;
   int n_bad = 0;
   int exp_seq [16];
   int n_exp;

   tq_zigzag_scan #(.COEF_W(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .coeff00_i     (blk[0]),
      .coeff01_i     (blk[1]),
      .coeff02_i     (blk[2]),
      .coeff03_i     (blk[3]),
      .coeff10_i     (blk[4]),
      .coeff11_i     (blk[5]),
      .coeff12_i     (blk[6]),
      .coeff13_i     (blk[7]),
      .coeff20_i     (blk[8]),
      .coeff21_i     (blk[9]),
      .coeff22_i     (blk[10]),
      .coeff23_i     (blk[11]),
      .coeff30_i     (blk[12]),
      .coeff31_i     (blk[13]),
      .coeff32_i     (blk[14]),
      .coeff33_i     (blk[15]),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .coeff_o       (coeff_o),
      .coeff_idx_o   (coeff_idx_o),
      .coeff_valid_o (coeff_valid_o),
      .coeff_ready_i (coeff_ready_i),
      .coeff_last_o  (coeff_last_o),
      .nz_cnt_o      (nz_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // coeffRC = 4*R+C+1, row-major
   task automatic load_ramp(input int sgn);
      for (int k = 0; k < 16; k++) blk[k] = 15'(sgn * (k + 1));
   endtask

   task automatic exp_ramp(input int sgn);
      int r [16] = '{1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16};
      for (int k = 0; k < 16; k++) exp_seq[k] = sgn * r[k];
      n_exp = 16;
   endtask

   // Present the block for one cycle from the next falling edge.
   task automatic send();
      @(negedge clk);
      in_valid_i = 1'b1;
      check("in_ready_idle", int'(in_ready_o), 1);
   endtask

   // Consume n_exp beats; toggle=1 drives ready 1,0,1,0...
   // keep_valid=1 keeps in_valid high and scrambles the inputs each cycle,
   // then presents the negated ramp right after the block ends.
   task automatic collect(input int exp_nz, input int toggle, input int keep_valid,
                          input int exp_iters);
      int beat;
      int iters;
      beat  = 0;
      iters = 0;
      while (beat < n_exp && iters < 64) begin
         @(negedge clk);
         if (keep_valid == 0) in_valid_i = 1'b0;
         else for (int k = 0; k < 16; k++) blk[k] = 15'(300 + iters * 16 + k);
         coeff_ready_i = (toggle == 0) ? 1'b1 : ((iters % 2) == 0);
         check("valid", int'(coeff_valid_o), 1);
         check("idx", int'(coeff_idx_o), beat);
         check("value", int'($signed(coeff_o)), exp_seq[beat]);
         check("last", int'(coeff_last_o), int'(beat == n_exp - 1));
         if (iters == 0) check("nz_cnt", int'(nz_cnt_o), exp_nz);
         if (coeff_ready_i) beat++;
         iters++;
      end
      if (beat < n_exp) check("timeout_beats", beat, n_exp);
      check("scan_cycles", iters, exp_iters);
      @(negedge clk);
      coeff_ready_i = 1'b0;
      if (keep_valid != 0) load_ramp(-1);
      check("ready_after", int'(in_ready_o), 1);
      check("valid_after", int'(coeff_valid_o), 0);
      check("nz_hold", int'(nz_cnt_o), exp_nz);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      in_valid_i    = 1'b0;
      coeff_ready_i = 1'b0;
      load_ramp(1);
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready_o), 1);
      check("rst_valid", int'(coeff_valid_o), 0);
      check("rst_last", int'(coeff_last_o), 0);
      check("rst_coeff", int'(coeff_o), 0);
      check("rst_idx", int'(coeff_idx_o), 0);
      check("rst_nz", int'(nz_cnt_o), 0);
      rst_n = 1'b1;

      // Ramp block, ready held high: 16 beats, ready again on cycle 17.
      load_ramp(1); exp_ramp(1);
      send();
      collect(16, 0, 0, 16);

      // Same block with ready toggling: each beat held one extra cycle.
      load_ramp(1); exp_ramp(1);
      send();
      collect(16, 1, 0, 31);

      // Sparse block: -5 at (0,0), 3 at (1,2) -> zigzag index 7.
      for (int k = 0; k < 16; k++) blk[k] = '0;
      blk[0] = 15'(-5);
      blk[6] = 15'(3);
      for (int k = 0; k < 16; k++) exp_seq[k] = 0;
      exp_seq[0] = -5;
      exp_seq[7] = 3;
`ifdef TQ_ZZ_SKIP_TRAIL_EN
      n_exp = 8;
`else
      n_exp = 16;
`endif
      send();
      collect(2, 0, 0, n_exp);

      // All-zero block.
      for (int k = 0; k < 16; k++) blk[k] = '0;
      for (int k = 0; k < 16; k++) exp_seq[k] = 0;
`ifdef TQ_ZZ_SKIP_TRAIL_EN
      n_exp = 1;
`else
      n_exp = 16;
`endif
      send();
      collect(0, 0, 0, n_exp);

      // Reset asserted while idx 6 is on the output.
      load_ramp(1);
      send();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid_i    = 1'b0;
         coeff_ready_i = 1'b1;
      end
      @(negedge clk);
      coeff_ready_i = 1'b0;
      check("pre_rst_idx", int'(coeff_idx_o), 6);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(coeff_valid_o), 0);
      check("mid_rst_in_ready", int'(in_ready_o), 1);
      check("mid_rst_idx", int'(coeff_idx_o), 0);
      check("mid_rst_coeff", int'(coeff_o), 0);
      check("mid_rst_nz", int'(nz_cnt_o), 0);
      @(negedge clk);
      check("rst_held_valid", int'(coeff_valid_o), 0);
      rst_n = 1'b1;
      load_ramp(1); exp_ramp(1);
      send();
      collect(16, 0, 0, 16);

      // in_valid held high with changing inputs during the scan; the next
      // block (negated ramp) is taken only once the first one has ended.
      load_ramp(1); exp_ramp(1);
      send();
      collect(16, 0, 1, 16);
      exp_ramp(-1);
      collect(16, 0, 0, 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tq_zigzag_scan.md
TQ_ZIGZAG_SCAN -- requirements
Module: tq_zigzag_scan

Interface
REQ-001 SHALL have parameter COEF_W, default 15, the signed width of each coefficient.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports coeffRC_i, input, COEF_W bits each, R,C in 0..3 (16 ports): quantized 4x4 block, R = row, C = column.
REQ-005 SHALL have port in_valid_i, input, 1 bit: the coeffRC_i block is valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the block accepts a new 4x4 block.
REQ-007 SHALL have port coeff_o, output, COEF_W bits: the scanned coefficient.
REQ-008 SHALL have port coeff_idx_o, output, 4 bits: zigzag position of coeff_o.
REQ-009 SHALL have port coeff_valid_o, output, 1 bit: coeff_o, coeff_idx_o and coeff_last_o are valid.
REQ-010 SHALL have port coeff_ready_i, input, 1 bit: the downstream entropy coder accepts the beat.
REQ-011 SHALL have port coeff_last_o, output, 1 bit: the final beat of the block.
REQ-012 SHALL have port nz_cnt_o, output, 5 bits: nonzero-coefficient count of the current block, 0..16.

Function
REQ-013 SHALL implement two states: IDLE and SCAN.
REQ-014 SHALL drive in_ready_o = 1 only in IDLE.
REQ-015 SHALL, on in_valid_i && in_ready_o, register all 16 coefficients into an internal buffer, go to SCAN, set the scan counter to 0, and register nz_cnt_o.
REQ-016 SHALL emit coefficients in zigzag order: 00,01,10,20,11,02,03,12,21,30,31,22,13,23,32,33.
REQ-017 SHALL assert coeff_valid_o from the cycle after acceptance (latency 1) for the whole of SCAN.
REQ-018 SHALL, when coeff_valid_o && coeff_ready_i, advance the counter by 1; otherwise it holds coeff_o, coeff_idx_o and coeff_last_o stable.
REQ-019 SHALL set coeff_idx_o equal to the counter value.
REQ-020 SHALL assert coeff_last_o on the final beat (index 15, except as changed by REQ-028).
REQ-021 SHALL, on a handshake of the last beat, return to IDLE, with in_ready_o = 1 in the next cycle (minimum 17 cycles per block).
REQ-022 SHALL compute nz_cnt_o as the count of coefficients != 0, hold it stable for the whole of SCAN, and leave it unchanged in IDLE.
REQ-023 SHALL ignore in_valid_i during SCAN; the block is not consumed and the upstream holds it.
REQ-024 SHALL pass coefficient values through unchanged; no saturation or sign change.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force: state IDLE, counter 0, coeff_valid_o 0, coeff_last_o 0, coeff_o 0, coeff_idx_o 0, nz_cnt_o 0, and buffer cleared; in_ready_o = 1 follows from IDLE.
REQ-026 SHALL, on reset during SCAN, abandon the block and not resume it; the first output after reset belongs to a newly accepted block.

Configuration
REQ-027 SHALL support macro TQ_ZZ_SKIP_TRAIL_EN, which controls trailing-zero truncation.
REQ-028 SHALL, with TQ_ZZ_SKIP_TRAIL_EN defined, register the highest zigzag index holding a nonzero coefficient at acceptance, end the scan at that index, and assert coeff_last_o there. An all-zero block emits exactly one beat: idx 0, value 0, last = 1.
REQ-029 SHALL, without TQ_ZZ_SKIP_TRAIL_EN, always emit 16 beats, with last at index 15.

Verification
REQ-030 SHALL cover: coeffRC_i = 4*R+C+1, coeff_ready_i held 1 -> beats 1,2,5,9,6,3,4,7,10,13,14,11,8,12,15,16; idx 0..15; last on the 16th beat; nz_cnt_o = 16; in_ready_o = 1 on cycle 17.
REQ-031 SHALL cover: the same block with coeff_ready_i toggling 1,0,1,0 -> each beat held while ready = 0; the sequence is unchanged; 32 cycles per block.
REQ-032 SHALL cover: coeff00 = -5, coeff12 = 3, all other coefficients 0 -> nz_cnt_o = 2. Without the macro: 16 beats, -5 at idx 0, 3 at idx 7. With the macro: 8 beats, last at idx 7.
REQ-033 SHALL cover: an all-zero block -> nz_cnt_o = 0. Without the macro: 16 zero beats. With the macro: a single beat, idx 0, last = 1.
REQ-034 SHALL cover: rst_n pulled low at idx 6 -> coeff_valid_o = 0 and in_ready_o = 1 immediately; the next accepted block starts at idx 0.
REQ-035 SHALL cover: in_valid_i held 1 during SCAN with a changing block -> the new block is accepted only after the last beat, and output values come only from the captured block.
